// File: rtl/morse_text_scroller.sv
`default_nettype none
// ============================================================================
// Module   : morse_text_scroller
// Purpose  : Holds up to MAX_CHARS decoded Morse characters and time-
//            multiplexes them onto a DIGITS-wide 7-segment bank. Each scan
//            slot presents one (code, length) pair to the downstream decoder
//            along with a one-hot digit enable. Static mode right-aligns the
//            last DIGITS characters; scroll mode walks a window across the
//            buffer and wraps back to the start.
// Revision : 1.0 - initial release
// ============================================================================
module morse_text_scroller #(
    parameter int MAX_CHARS  = 8,
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 16,
    parameter int SCROLL_DIV = 4,
    parameter int CW         = $clog2(MAX_CHARS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [5*MAX_CHARS-1:0] seq_in,
    input  logic [3*MAX_CHARS-1:0] len_in,
    input  logic [CW-1:0]          count_in,
    input  logic                   mode,
    output logic [4:0]             code_out,
    output logic [2:0]             len_out,
    output logic [DIGITS-1:0]      digit_en,
    output logic                   blank,
    output logic [CW-1:0]          window,
    output logic                   wrap
);

    // Counter widths; single-value counters still get one bit.
    localparam int c_sw = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
    localparam int c_dw = (DIGITS     > 1) ? $clog2(DIGITS)     : 1;
    localparam int c_pw = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    // Slot index = window + digit can reach 2*MAX_CHARS-2, so one extra bit.
    localparam int c_iw = CW + 1;

    localparam logic [c_sw-1:0] c_sc_last     = c_sw'(SCAN_DIV - 1);
    localparam logic [c_dw-1:0] c_d_last      = c_dw'(DIGITS - 1);
    localparam logic [c_pw-1:0] c_scroll_last = c_pw'(SCROLL_DIV - 1);
    localparam logic [CW-1:0]   c_max_cw      = CW'(MAX_CHARS);
    localparam logic [CW-1:0]   c_digits_cw   = CW'(DIGITS);
    localparam logic [CW-1:0]   c_one_cw      = CW'(1);

    // State
    logic [c_sw-1:0]        r_sc;
    logic [c_dw-1:0]        r_d;
    logic [c_pw-1:0]        r_scroll;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          r_window;
    logic                   r_mode_q;
    logic [5*MAX_CHARS-1:0] r_seq;
    logic [3*MAX_CHARS-1:0] r_len;

    // Registered outputs
    logic [4:0]             r_code_out;
    logic [2:0]             r_len_out;
    logic [DIGITS-1:0]      r_digit_en;
    logic                   r_blank;
    logic                   r_wrap;

    // Combinational helpers
    logic                   w_sc_last;
    logic                   w_d_last;
    logic                   w_scan_done;
    logic                   w_step;
    logic [CW-1:0]          w_static_win;
    logic [CW-1:0]          w_load_count;
    logic [c_iw-1:0]        w_idx;
    logic                   w_idx_valid;
    logic [4:0]             w_sel_code;
    logic [2:0]             w_sel_len;
    logic [DIGITS-1:0]      w_den_next;

    assign w_sc_last    = (r_sc == c_sc_last);
    assign w_d_last     = (r_d == c_d_last);
    assign w_scan_done  = w_sc_last && w_d_last;
    assign w_step       = w_scan_done && (r_scroll == c_scroll_last);
    assign w_static_win = (r_count > c_digits_cw) ? (r_count - c_digits_cw) : '0;
    assign w_load_count = (count_in > c_max_cw) ? c_max_cw : count_in;
    assign w_idx        = {1'b0, r_window} + c_iw'(r_d);
    assign w_idx_valid  = (w_idx < {1'b0, r_count});

    // Pick the buffered character addressed by the current slot index.
    always_comb begin
        w_sel_code = '0;
        w_sel_len  = '0;
        for (int i = 0; i < MAX_CHARS; i++) begin
            if (w_idx == c_iw'(i)) begin
                w_sel_code = r_seq[5*(MAX_CHARS-1-i)+4 -: 5];
                w_sel_len  = r_len[3*(MAX_CHARS-1-i)+2 -: 3];
            end
        end
    end

    // One-hot decode of the active digit (bit 0 = leftmost).
    always_comb begin
        w_den_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_den_next[i] = (r_d == c_dw'(i));
        end
    end

    // Free-running slot timer and digit index; only reset touches them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sc <= '0;
            r_d  <= '0;
        end else if (w_sc_last) begin
            r_sc <= '0;
            r_d  <= w_d_last ? '0 : r_d + c_dw'(1);
        end else begin
            r_sc <= r_sc + c_sw'(1);
        end
    end

    // Character buffer and saturated valid count, captured on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq   <= '0;
            r_len   <= '0;
            r_count <= '0;
        end else if (load) begin
            r_seq   <= seq_in;
            r_len   <= len_in;
            r_count <= w_load_count;
        end
    end

    // Window placement: static right-alignment or scroll stepping with wrap.
    // Any load parks the window at 0 so it can never exceed a shrunken count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window <= '0;
            r_scroll <= '0;
            r_mode_q <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_mode_q <= mode;
            r_wrap   <= 1'b0;
            if (!mode) begin
                r_scroll <= '0;
                r_window <= load ? '0 : w_static_win;
            end else if (!r_mode_q) begin
                // Entering scroll mode restarts from the first character.
                r_window <= '0;
                r_scroll <= '0;
            end else begin
                if (w_scan_done) begin
                    r_scroll <= (r_scroll == c_scroll_last) ? '0 : r_scroll + c_pw'(1);
                end
                if (load) begin
                    r_window <= '0;
                end else if (w_step && (r_count != '0)) begin
                    if (r_window == r_count - c_one_cw) begin
                        r_window <= '0;
                        r_wrap   <= 1'b1;
                    end else begin
                        r_window <= r_window + c_one_cw;
                    end
                end
            end
        end
    end

    // Slot outputs registered from the state held before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code_out <= '0;
            r_len_out  <= '0;
            r_blank    <= 1'b1;
            r_digit_en <= DIGITS'(1);
        end else begin
            r_digit_en <= w_den_next;
            if (w_idx_valid) begin
                r_code_out <= w_sel_code;
                r_len_out  <= w_sel_len;
                r_blank    <= 1'b0;
            end else begin
                r_code_out <= '0;
                r_len_out  <= '0;
                r_blank    <= 1'b1;
            end
        end
    end

    assign code_out = r_code_out;
    assign len_out  = r_len_out;
    assign digit_en = r_digit_en;
    assign blank    = r_blank;
    assign window   = r_window;
    assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_morse_text_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_morse_text_scroller
// Purpose  : Self-checking bench for morse_text_scroller. A behavioural model
//            tracks time since reset, the character buffer and the window
//            position, and predicts every output on every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_morse_text_scroller;

    localparam int MAXC = 8;
    localparam int DIG  = 4;
    localparam int SDIV = 16;
    localparam int RDIV = 4;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int SCAN_PERIOD = SDIV * DIG;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic [5*MAXC-1:0] seq_in;
    logic [3*MAXC-1:0] len_in;
    logic [CW-1:0]     count_in;
    logic              mode;
    logic [4:0]        code_out;
    logic [2:0]        len_out;
    logic [DIG-1:0]    digit_en;
    logic              blank;
    logic [CW-1:0]     window;
    logic              wrap;

    morse_text_scroller #(
        .MAX_CHARS (MAXC),
        .DIGITS    (DIG),
        .SCAN_DIV  (SDIV),
        .SCROLL_DIV(RDIV),
        .CW        (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .seq_in  (seq_in),
        .len_in  (len_in),
        .count_in(count_in),
        .mode    (mode),
        .code_out(code_out),
        .len_out (len_out),
        .digit_en(digit_en),
        .blank   (blank),
        .window  (window),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    // Model state
    int m_cyc;
    int m_count;
    int m_window;
    int m_scans;
    int m_mode_prev;
    int m_chars [MAXC];
    int m_lens  [MAXC];
    int e_code, e_len, e_blank, e_den, e_wrap;

    int n_tests = 0;
    int n_fail  = 0;
    int wraps_seen;

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk("code_out", int'(code_out), e_code);
        chk("len_out",  int'(len_out),  e_len);
        chk("blank",    int'(blank),    e_blank);
        chk("digit_en", int'(digit_en), e_den);
        chk("window",   int'(window),   m_window);
        chk("wrap",     int'(wrap),     e_wrap);
    endtask

    task automatic model_reset();
        m_cyc = 0; m_count = 0; m_window = 0; m_scans = 0; m_mode_prev = 0;
        for (int i = 0; i < MAXC; i++) begin
            m_chars[i] = 0;
            m_lens[i]  = 0;
        end
        e_code = 0; e_len = 0; e_blank = 1; e_den = 1; e_wrap = 0;
    endtask

    // Advance the model across one rising edge using the inputs seen there.
    task automatic model_edge();
        int d, idx, nwin, nwrap;
        bit scan_done, step;
        d   = (m_cyc / SDIV) % DIG;
        idx = m_window + d;
        e_den = 1 << d;
        if (idx < m_count) begin
            e_code = m_chars[idx]; e_len = m_lens[idx]; e_blank = 0;
        end else begin
            e_code = 0; e_len = 0; e_blank = 1;
        end
        scan_done = ((m_cyc % SCAN_PERIOD) == SCAN_PERIOD - 1);
        nwin  = m_window;
        nwrap = 0;
        if (mode == 1'b0) begin
            nwin = load ? 0 : ((m_count > DIG) ? m_count - DIG : 0);
        end else if (m_mode_prev == 0) begin
            nwin = 0;
            m_scans = 0;
        end else begin
            step = scan_done && (m_scans == RDIV - 1);
            if (scan_done) m_scans = (m_scans + 1) % RDIV;
            if (load) nwin = 0;
            else if (step && m_count > 0) begin
                if (m_window == m_count - 1) begin
                    nwin = 0; nwrap = 1;
                end else begin
                    nwin = m_window + 1;
                end
            end
        end
        m_window = nwin;
        e_wrap   = nwrap;
        if (load) begin
            for (int i = 0; i < MAXC; i++) begin
                m_chars[i] = int'(seq_in[5*(MAXC-1-i)+4 -: 5]);
                m_lens[i]  = int'(len_in[3*(MAXC-1-i)+2 -: 3]);
            end
            m_count = (int'(count_in) > MAXC) ? MAXC : int'(count_in);
        end
        m_mode_prev = int'(mode);
        m_cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (wrap) wraps_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a buffer image and pulse load for one edge.
    task automatic do_load(input int cnt, input bit rnd);
        for (int i = 0; i < MAXC; i++) begin
            if (rnd) begin
                seq_in[5*(MAXC-1-i)+4 -: 5] = 5'($urandom);
                len_in[3*(MAXC-1-i)+2 -: 3] = 3'($urandom);
            end else begin
                seq_in[5*(MAXC-1-i)+4 -: 5] = 5'(i + 1);
                len_in[3*(MAXC-1-i)+2 -: 3] = 3'(i + 1);
            end
        end
        count_in = CW'(cnt);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; load = 1'b0; mode = 1'b0;
        seq_in = '0; len_in = '0; count_in = '0;
        wraps_seen = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Put some state in place, then reset in the middle of a slot.
        do_load(6, 1'b0);
        run(20);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        check_outputs();
        run(40);

        // Static mode, six characters 1..6 right-aligned.
        do_load(6, 1'b0);
        run(2);
        chk("static6_window", int'(window), 2);
        run(130);

        // Static mode, short buffer leaves trailing digits blank.
        do_load(2, 1'b0);
        run(130);

        // Overflowing count saturates to buffer depth.
        do_load(12, 1'b1);
        run(2);
        chk("overflow_window", int'(window), MAXC - DIG);
        run(70);

        // Scroll mode over five characters, more than a full lap.
        do_load(5, 1'b1);
        mode = 1'b1;
        wraps_seen = 0;
        run(6 * RDIV * SCAN_PERIOD + 40);
        chk("scroll5_wrapped", int'(wraps_seen > 0), 1);

        // Empty buffer in scroll mode never wraps.
        do_load(0, 1'b1);
        wraps_seen = 0;
        run(2100);
        chk("empty_no_wrap", wraps_seen, 0);

        // Load colliding with a scroll step while window sits at 3.
        do_load(5, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (m_window == 3 && m_scans == RDIV - 1 && m_mode_prev == 1 &&
                (m_cyc % SCAN_PERIOD) == SCAN_PERIOD - 1)
                found = 1'b1;
            else
                tick();
        end
        chk("collision_reached", int'(found), 1);
        do_load(7, 1'b1);
        chk("collision_window", int'(window), 0);
        chk("collision_wrap", int'(wrap), 0);
        run(20);

        // Randomised loads, counts and mode flips.
        for (int k = 0; k < 24; k++) begin
            mode = 1'($urandom);
            if ($urandom_range(0, 3) != 0) do_load(int'($urandom_range(0, 15)), 1'b1);
            run(int'($urandom_range(30, 600)));
            if ($urandom_range(0, 1) == 1) begin
                mode = ~mode;
                run(int'($urandom_range(5, 300)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_text_scroller.md
# morse_text_scroller

Parametrised successor to the single-position last-letter selector: holds a buffer of up to MAX_CHARS decoded Morse characters and time-multiplexes them onto a DIGITS-wide 7-segment bank. It drives one (code, length) pair per scan slot to the downstream morse_decoder, together with a one-hot digit enable. Two modes: static, which shows the last DIGITS characters right-aligned, and scroll, which moves a window across the buffer with wrap-around. Sits between the input sequencer (final_seq/final_num arrays) and the decoder/anode drivers.

## Interface
- MAX_CHARS, 8: buffer depth in characters (≥2)
- DIGITS, 4: physical display digits (1..MAX_CHARS)
- SCAN_DIV, 16: clk cycles per digit slot (≥2)
- SCROLL_DIV, 4: full display scans per scroll step (≥1)
- CW, $clog2(MAX_CHARS+1): width of count fields
- clk  in  1  block clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- load  in  1  single-cycle pulse; latch seq_in/len_in/count_in
- seq_in  in  5*MAX_CHARS  char i at bits [5*(MAX_CHARS-1-i)+4 -: 5]; char 0 at MSBs
- len_in  in  3*MAX_CHARS  element count of char i at [3*(MAX_CHARS-1-i)+2 -: 3]
- count_in  in  CW  number of valid characters
- mode  in  1  0 = static, 1 = scroll
- code_out  out  5  character code to decoder
- len_out  out  3  element count to decoder
- digit_en  out  DIGITS  one-hot, active-high; bit 0 = leftmost digit
- blank  out  1  current slot shows nothing
- window  out  CW  buffer index shown on digit 0
- wrap  out  1  one-cycle pulse when the scroll window returns to 0

## Operation
- Buffer: on load, latch seq/len; count = min(count_in, MAX_CHARS). Buffer, count and window are reset to 0.
- Scan counter sc runs 0..SCAN_DIV-1. At sc = SCAN_DIV-1, digit index d advances modulo DIGITS. digit_en = 1<<d.
- Slot index idx = window + d. If idx ≥ count: code_out = 0, len_out = 0, blank = 1. Otherwise output buffer char idx with blank = 0.
- Static mode: window = count > DIGITS ? count-DIGITS : 0, recomputed every cycle. The last characters land on the rightmost digits; when count < DIGITS, trailing digits blank.
- Scroll mode: scan-complete event = sc terminal with d = DIGITS-1. Scroll counter counts these events modulo SCROLL_DIV. On its terminal event, window increments. When window = count-1 it wraps to 0 instead, and wrap pulses for one cycle.
- count = 0: window held 0, all slots blank, wrap never asserts.
- Mode 0→1 transition: window and scroll counter cleared on that cycle. Mode 1→0: window takes the static value next cycle.
- load in the same cycle as a scroll step: load wins; window = 0, no wrap.
- A count decrease via load always forces window = 0, so window < count holds whenever count > 0.
- Scan counter and d are never disturbed by load or mode; only rst clears them.

## Timing
- Reset (asynchronous assert): sc = 0, d = 0, digit_en = 1, code_out = 0, len_out = 0, blank = 1, window = 0, wrap = 0, count = 0, buffer cleared.
- Outputs are registered. code_out, len_out, blank and digit_en reflect the state of the preceding edge.
- The digit switch is visible 1 cycle after the sc terminal cycle. The slot stays stable for SCAN_DIV cycles.
- Load sampled at edge t; new characters appear on outputs at edge t+1 for the current slot.
- Scroll step period = SCROLL_DIV × DIGITS × SCAN_DIV cycles. wrap is high the cycle after the wrapping step edge.
- Deassert rst synchronously to clk externally; rst asserted mid-scan aborts immediately.

## Test plan
- Reset: assert rst mid-scan -> digit_en=0001, blank=1, code_out=0, window=0 within the same cycle; after release, d advances every 16 cycles.
- Static, defaults: load 6 chars (codes 1..6, lens 1..6), mode=0 -> window=2; digits 0..3 show codes 3,4,5,6 in order, each slot 16 cycles.
- Static short buffer: count_in=2 -> digits 0,1 show codes 1,2; digits 2,3 blank=1 with code 0.
- Scroll, count=5: window steps every 256 cycles (0,1,2,3,4,0); wrap pulses for one cycle on 4→0; digit 3 is blank at window=2.
- Overflow/empty: count_in=12 saturates to 8. count_in=0 in scroll -> all slots blank, wrap stays 0 for ≥2048 cycles.
- Collision: load asserted on the scroll-step edge with window=3 -> window=0, wrap=0, new data on outputs next cycle.
